regfile_debug_port: RTL and testbench

- Debug-side initiator for the 32x32 RISC-V register file.
- Accepts single-register read, single-register write and dump-all commands over a valid/ready command channel.
- Drives the register file's write port and one read port, and returns register contents over a valid/ready response stream.
- Sits between the debug/UART bridge and the register file. While this block is busy, the core is stalled externally and the core's register-file port mux selects this block.

---
 rtl/regfile_debug_pkg.sv | 30 +++
 rtl/regfile_debug_port_reg.sv | 20 ++
 rtl/regfile_debug_port.sv | 159 +++++++++++++++
 tb/tb_regfile_debug_port.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_debug_pkg.sv
// Shared types for the register-file debug port: command opcodes, FSM states and
// address constants.
package regfile_debug_pkg;

  localparam int unsigned ADDR_W = 5;

  // Highest register index; a dump stops after responding for this address.
  localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;

  typedef enum logic [1:0] {
    READ  = 2'b00,
    WRITE = 2'b01,
    DUMP  = 2'b10,
    RSVD  = 2'b11
  } dbg_op_t;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StWrite = 2'b01,
    StRead  = 2'b10,
    StResp  = 2'b11
  } dbg_state_t;

  // True when the response just captured for addr closes the command.
  function automatic logic is_last_rsp(dbg_op_t op, logic [ADDR_W-1:0] addr,
                                       logic [ADDR_W-1:0] last_addr);
    return (op != DUMP) || (addr == last_addr);
  endfunction

endpackage

// File: rtl/regfile_debug_port_reg.sv
// Generic enabled register with an active-high asynchronous reset to zero.
module regfile_debug_port_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         ena,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      q <= '0;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_debug_port.sv
// Debug-side initiator for the 32x32 RISC-V register file: single read, single write
// with read-back, and dump-all, returning register contents over a valid/ready stream.
module regfile_debug_port
  import regfile_debug_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  // Response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              busy,
  // Register file ports
  output logic              rf_wr_ena,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data
);

  localparam logic [ADDR_W-1:0] DumpLastAddr = ADDR_W'(N_REGS - 1);
  localparam int unsigned       PayloadW     = ADDR_W + DATA_W;

  dbg_state_t        state_q, state_d;
  dbg_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic              rsp_err_q, rsp_err_d;

  dbg_op_t           cmd_op_e;
  logic              accept;
  logic              rsp_hs;
  logic              rsvd_cap;
  logic              payload_ena;
  logic [PayloadW-1:0] payload_d, payload_q;
  logic              arst;

  assign cmd_op_e  = dbg_op_t'(cmd_op);
  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid & cmd_ready;
  assign rsp_hs    = rsp_valid_q & rsp_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d   = cmd_op_e;
          data_d = cmd_data;
          addr_d = (cmd_op_e == DUMP) ? '0 : cmd_addr;
          unique case (cmd_op_e)
            READ, DUMP: state_d = StRead;
            WRITE:      state_d = StWrite;
            default: begin
              // Reserved opcode answers immediately with an error response.
              state_d     = StResp;
              rsp_valid_d = 1'b1;
              rsp_last_d  = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end
      StWrite: begin
        state_d = StRead;
      end
      StRead: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_last_d  = is_last_rsp(op_q, addr_q, DumpLastAddr);
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = StIdle;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRead;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_q        <= READ;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Payload loads from the register file in READ, or with {cmd_addr, 0} for a reserved op.
  assign rsvd_cap    = accept & (cmd_op_e == RSVD);
  assign payload_ena = (state_q == StRead) | rsvd_cap;
  assign payload_d   = rsvd_cap ? {cmd_addr, {DATA_W{1'b0}}} : {addr_q, rf_rd_data};
  assign arst        = ~rst;

  regfile_debug_port_reg #(
    .W(PayloadW)
  ) u_payload_reg (
    .clk (clk),
    .arst(arst),
    .ena (payload_ena),
    .d   (payload_d),
    .q   (payload_q)
  );

  assign rsp_addr  = payload_q[PayloadW-1:DATA_W];
  assign rsp_data  = payload_q[DATA_W-1:0];
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != StIdle);

  assign rf_wr_ena  = (state_q == StWrite);
  assign rf_wr_addr = addr_q;
  assign rf_wr_data = data_q;
  assign rf_rd_addr = addr_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Scoreboard bench for regfile_debug_port with a behavioural 32x32 register file.
module tb_regfile_debug_port;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        busy;
  logic        rf_wr_ena;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;

  logic [31:0] rf_mem [32];
  rsp_t        exp_q[$];
  wr_t         wr_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rsp   = 0;
  int          rdy_mode = 0;

  regfile_debug_port dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .rf_wr_ena (rf_wr_ena),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: x0 reads as zero and ignores writes.
  always @(posedge clk) begin
    if (rf_wr_ena && rf_wr_addr != 5'd0) rf_mem[rf_wr_addr] <= rf_wr_data;
  end
  assign rf_rd_data = (rf_rd_addr == 5'd0) ? 32'h0 : rf_mem[rf_rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // rsp_ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Response and write monitor.
  initial begin
    logic        prev_stall;
    logic [39:0] prev_rsp;
    rsp_t        e;
    wr_t         w;
    prev_stall = 1'b0;
    prev_rsp   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("rsp_stable", {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err}, prev_rsp);
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", {rsp_addr, rsp_data}, 64'h0);
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got addr %0d data %0h want none", rsp_addr, rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp", {rsp_addr, rsp_data, rsp_last, rsp_err}, e);
          end
        end
        if (rf_wr_ena) begin
          if (wr_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h want none", rf_wr_addr,
                     rf_wr_data);
          end else begin
            w = wr_q.pop_front();
            check("rf_write", {rf_wr_addr, rf_wr_data}, w);
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_rsp   = {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic push_rsp(input logic [4:0] a, input logic [31:0] d, input logic l,
                          input logic er);
    rsp_t r;
    r.addr = a; r.data = d; r.last = l; r.err = er;
    exp_q.push_back(r);
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int cnt;
    cnt = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    if (cnt >= 200) check("cmd_accept_timeout", 64'(cnt), 64'h0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_write(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
    push_rsp(a, (a == 5'd0) ? 32'h0 : d, 1'b1, 1'b0);
    send_cmd(2'b01, a, d);
  endtask

  task automatic wait_idle(input string name);
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || busy) && cnt < 1000) begin
      @(posedge clk); #1; cnt++;
    end
    check({name, "_timeout"}, 64'(cnt >= 1000), 64'h0);
    check({name, "_wr_pending"}, 64'(wr_q.size()), 64'h0);
  endtask

  initial begin
    int   base;
    int   cnt;
    logic saw_ready;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0;
    #2;
    check("reset_outputs", {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, busy, rf_wr_ena},
          64'h0);
    check("reset_rf_ports", {rf_wr_addr, rf_wr_data, rf_rd_addr}, 64'h0);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // WRITE x5 with latency checks
    send_write(5'd5, 32'hDEADBEEF);
    check("wr_ena_e1", {rf_wr_ena, rf_wr_addr, rf_wr_data}, {1'b1, 5'd5, 32'hDEADBEEF});
    check("wr_busy", {busy, cmd_ready}, 2'b10);
    @(posedge clk); #1;
    check("wr_after_e1", {rf_wr_ena, rsp_valid}, 2'b00);
    @(posedge clk); #1;
    check("wr_rsp_e2", rsp_valid, 1'b1);
    wait_idle("write5");

    // WRITE x0: write issued, read-back zero
    send_write(5'd0, 32'h12345678);
    wait_idle("write0");

    // Reserved opcode
    push_rsp(5'd7, 32'h0, 1'b1, 1'b1);
    send_cmd(2'b11, 5'd7, 32'hCAFEF00D);
    check("rsvd_rsp_e0", {rsp_valid, rf_wr_ena}, 2'b10);
    wait_idle("rsvd");

    // Preload xi = i * 0x01010101
    for (int i = 1; i < 32; i++) begin
      send_write(5'(i), 32'(i) * 32'h01010101);
      wait_idle("preload");
    end

    // DUMP with random backpressure
    rdy_mode = 1;
    base = n_rsp;
    for (int i = 0; i < 32; i++) push_rsp(5'(i), 32'(i) * 32'h01010101, i == 31, 1'b0);
    send_cmd(2'b10, 5'd17, 32'h0);
    saw_ready = 1'b0;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 2000) begin
      if (cmd_ready) saw_ready = 1'b1;
      @(posedge clk); #1; cnt++;
    end
    check("dump_cmd_ready_low", saw_ready, 1'b0);
    rdy_mode = 0;
    wait_idle("dump");
    check("dump_rsp_count", 64'(n_rsp - base), 64'd32);

    // READ x31 with 10-cycle stall; a command offered during the stall is refused
    rdy_mode = 2;
    push_rsp(5'd31, 32'h1F1F1F1F, 1'b1, 1'b0);
    send_cmd(2'b00, 5'd31, 32'h0);
    check("read_rsp_not_yet", rsp_valid, 1'b0);
    @(posedge clk); #1;
    check("read_rsp_e1", rsp_valid, 1'b1);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'd3; cmd_data = 32'h0BAD0BAD;
    for (int i = 0; i < 10; i++) begin
      check("stall_cmd_ready", {cmd_ready, rsp_valid}, 2'b01);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rdy_mode = 0;
    wait_idle("read31");
    check("idle_cmd_ready", cmd_ready, 1'b1);

    // Reset during the 5th READ of a dump
    base = n_rsp;
    for (int i = 0; i < 32; i++) push_rsp(5'(i), 32'(i) * 32'h01010101, i == 31, 1'b0);
    send_cmd(2'b10, 5'd0, 32'h0);
    cnt = 0;
    while (!(busy && !rsp_valid && rf_rd_addr == 5'd4) && cnt < 200) begin
      @(posedge clk); #1; cnt++;
    end
    check("dump_reach_read4", 64'(cnt >= 200), 64'h0);
    rst = 1'b0;
    #1;
    check("midreset_outputs",
          {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, busy, rf_wr_ena}, 64'h0);
    check("midreset_rd_addr", rf_rd_addr, 5'd0);
    check("midreset_rsp_count", 64'(n_rsp - base), 64'd4);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push_rsp(5'd9, 32'h09090909, 1'b1, 1'b0);
    send_cmd(2'b00, 5'd9, 32'h0);
    wait_idle("post_reset_read");
    check("post_reset_rsp_count", 64'(n_rsp - base), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
